// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter slice.
//   AW        - VRAM address width
//   DW        - VRAM data width (one RGB332 pixel)
//   VRAM_SIZE - number of valid bytes (160x100 frame)
//   host_state_e - host access FSM states
package vram_pkg;

   localparam int unsigned AW        = 14;
   localparam int unsigned DW        = 8;
   localparam int unsigned VRAM_SIZE = 16000;

   typedef enum logic [1:0] {
      StIdle,
      StWrAck,
      StRdWait,
      StRdAck
   } host_state_e;

endpackage

// File: rtl/vram_clear_seq.sv
// Fill sequencer: writes one latched byte to addresses 0..VRAM_SIZE-1 in ascending order.
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_start        - start pulse, ignored while busy
//   i_value        - fill byte, sampled with i_start
//   i_stall        - higher-priority access this cycle; hold the current address
//   o_busy         - fill in progress
//   o_we           - this cycle carries a fill write
//   o_addr/o_wdata - address and data of the fill write
module vram_clear_seq #(
   parameter int unsigned AW        = vram_pkg::AW,
   parameter int unsigned DW        = vram_pkg::DW,
   parameter int unsigned VRAM_SIZE = vram_pkg::VRAM_SIZE
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [DW-1:0] i_value,
   input  logic          i_stall,
   output logic          o_busy,
   output logic          o_we,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_wdata
);

   localparam logic [AW-1:0] LastAddr = AW'(VRAM_SIZE - 1);

   logic          r_busy;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_value;
   logic          w_write;

   // A stalled cycle keeps the address so no location is skipped.
   assign w_write = r_busy & ~i_stall;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy  <= 1'b0;
         r_addr  <= '0;
         r_value <= '0;
      end else if (!r_busy) begin
         if (i_start) begin
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_value <= i_value;
         end
      end else if (w_write) begin
         if (r_addr == LastAddr) begin
            r_busy <= 1'b0;
            r_addr <= '0;
         end else begin
            r_addr <= r_addr + AW'(1);
         end
      end
   end

   assign o_busy  = r_busy;
   assign o_we    = w_write;
   assign o_addr  = r_addr;
   assign o_wdata = r_value;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch > fill > host, at most one access per cycle.
// Ports:
//   pclk, reset                - pixel clock, asynchronous active-high reset
//   vid_req/vid_addr           - video fetch strobe and address (presented same cycle)
//   vid_data/vid_valid         - fetched byte, valid 2 cycles after vid_req
//   cpu_req/we/addr/wdata      - host request, held until cpu_ack
//   cpu_rdata/cpu_ack          - host read data (held until next read), completion pulse
//   clr_start/clr_value        - start a full-VRAM fill with the given byte
//   clr_busy                   - fill in progress
//   mem_addr/we/wdata/rdata    - single-port RAM with 1-cycle registered read
module vram_arbiter #(
   parameter int unsigned AW        = vram_pkg::AW,
   parameter int unsigned DW        = vram_pkg::DW,
   parameter int unsigned VRAM_SIZE = vram_pkg::VRAM_SIZE
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_value,
   output logic          clr_busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   import vram_pkg::host_state_e;
   import vram_pkg::StIdle;
   import vram_pkg::StWrAck;
   import vram_pkg::StRdWait;
   import vram_pkg::StRdAck;

   host_state_e   r_state;
   host_state_e   w_state_nxt;
   logic          w_grant;
   logic          w_in_range;
   logic          r_oob;
   logic          r_vid_pend;
   logic          r_vid_valid;
   logic [DW-1:0] r_vid_data;
   logic [DW-1:0] r_cpu_rdata;

   logic          w_clr_busy;
   logic          w_clr_we;
   logic [AW-1:0] w_clr_addr;
   logic [DW-1:0] w_clr_wdata;

   vram_clear_seq #(
      .AW        (AW),
      .DW        (DW),
      .VRAM_SIZE (VRAM_SIZE)
   ) u_clear_seq (
      .i_clk   (pclk),
      .i_rst   (reset),
      .i_start (clr_start),
      .i_value (clr_value),
      .i_stall (vid_req),
      .o_busy  (w_clr_busy),
      .o_we    (w_clr_we),
      .o_addr  (w_clr_addr),
      .o_wdata (w_clr_wdata)
   );

   assign w_in_range = (32'(cpu_addr) < VRAM_SIZE);

   // Host FSM next state; a grant only happens from idle, so the ack cycle never re-grants.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (cpu_req && !vid_req && !w_clr_busy) begin
               w_grant     = 1'b1;
               w_state_nxt = cpu_we ? StWrAck : StRdWait;
            end
         end
         StWrAck:  w_state_nxt = StIdle;
         StRdWait: w_state_nxt = StRdAck;
         StRdAck:  w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   // Memory port mux. Out-of-range host accesses still take the grant but touch nothing.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (reset) begin
         mem_we = 1'b0;
      end else if (vid_req) begin
         mem_addr = vid_addr;
      end else if (w_clr_we) begin
         mem_addr  = w_clr_addr;
         mem_we    = 1'b1;
         mem_wdata = w_clr_wdata;
      end else if (w_grant && w_in_range) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_we ? cpu_wdata : '0;
      end
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_oob       <= 1'b0;
         r_vid_pend  <= 1'b0;
         r_vid_valid <= 1'b0;
         r_vid_data  <= '0;
         r_cpu_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_vid_pend  <= vid_req;
         r_vid_valid <= r_vid_pend;
         if (w_grant) begin
            r_oob <= ~w_in_range;
         end
         // RAM data for a request appears the cycle after it was addressed.
         if (r_vid_pend) begin
            r_vid_data <= mem_rdata;
         end
         if (r_state == StRdWait) begin
            r_cpu_rdata <= r_oob ? '0 : mem_rdata;
         end
      end
   end

   assign vid_valid = r_vid_valid;
   assign vid_data  = r_vid_data;
   assign cpu_rdata = r_cpu_rdata;
   assign cpu_ack   = (r_state == StWrAck) || (r_state == StRdAck);
   assign clr_busy  = w_clr_busy;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a behavioural RAM and reference memory image.
module tb_vram_arbiter;

   localparam int unsigned AW    = 14;
   localparam int unsigned DW    = 8;
   localparam int unsigned VSIZE = 16000;
   localparam int unsigned MEMW  = 1 << AW;

   logic          pclk = 1'b0;
   logic          reset = 1'b1;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          clr_start = 1'b0;
   logic [DW-1:0] clr_value = '0;
   logic          clr_busy;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 pclk = ~pclk;

   vram_arbiter #(
      .AW        (AW),
      .DW        (DW),
      .VRAM_SIZE (VSIZE)
   ) dut (
      .pclk      (pclk),
      .reset     (reset),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .clr_start (clr_start),
      .clr_value (clr_value),
      .clr_busy  (clr_busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // RAM model with a backdoor write port used only while the DUT is quiet.
   logic [7:0]    ram [MEMW];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [7:0]    bd_data = '0;

   always @(posedge pclk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] ref_mem [MEMW];
   logic [7:0] last_rdata = 8'h00;
   logic       vid_chk_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Video checker: every fetch must come back exactly two cycles later with the model byte.
   logic [1:0] vh_req = 2'b00;
   logic [1:0] vh_chk = 2'b00;
   logic [7:0] vh_data [2];

   always @(negedge pclk) begin
      if (reset) begin
         vh_req <= 2'b00;
         vh_chk <= 2'b00;
      end else begin
         chk("vid_valid timing", 32'(vid_valid), 32'(vh_req[1]));
         if (vh_req[1] && vh_chk[1]) chk("vid_data", 32'(vid_data), 32'(vh_data[1]));
         if (vid_req) begin
            chk("vid mem_addr", 32'(mem_addr), 32'(vid_addr));
            chk("vid mem_we", 32'(mem_we), 0);
         end
         vh_req     <= {vh_req[0], vid_req};
         vh_chk     <= {vh_chk[0], vid_chk_en};
         vh_data[1] <= vh_data[0];
         vh_data[0] <= ref_mem[vid_addr];
      end
   end

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      step();
      bd_we   = 1'b0;
   endtask

   // One host transaction; vid_req is held high for the first vid_hold cycles.
   task automatic host_op(input string name, input logic we, input logic [AW-1:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd, input int vid_hold);
      int ack_at = vid_hold + (we ? 1 : 2);
      bit in_rng = (32'(addr) < VSIZE);
      int bad_ack = 0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      for (int c = 0; c <= ack_at; c++) begin
         vid_req  = (c < vid_hold);
         vid_addr = AW'($urandom);
         @(negedge pclk);
         if (cpu_ack !== (c == ack_at)) bad_ack++;
         if (c == vid_hold) begin
            chk({name, " grant mem_we"}, 32'(mem_we), 32'(we && in_rng));
            if (in_rng) chk({name, " grant mem_addr"}, 32'(mem_addr), 32'(addr));
         end
         if (c == ack_at) begin
            chk({name, " ack cycle mem_we"}, 32'(mem_we), 0);
            if (we) chk({name, " rdata hold"}, 32'(cpu_rdata), 32'(last_rdata));
            else chk({name, " rdata"}, 32'(cpu_rdata), 32'(exp_rd));
         end
         step();
         if (c == vid_hold && we && in_rng) ref_mem[addr] = wdata;
      end
      cpu_req = 1'b0;
      vid_req = 1'b0;
      chk({name, " ack timing"}, bad_ack, 0);
      if (!we) last_rdata = exp_rd;
      @(negedge pclk);
      chk({name, " quiet after ack"}, {30'd0, cpu_ack, mem_we}, 0);
      step();
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata;
      logic [7:0]    exp_rd;
      int            vid_hold;
   } host_vec_t;

   initial begin
      host_vec_t vecs [11];
      int bad, busy_cyc, vid_cyc, seq, bad_seq, early, cyc, g;
      bit done, got, found;
      logic [AW-1:0] a;
      logic [7:0] d;

      vecs[0]  = '{1'b1, 14'h0100, 8'h3C, 8'h00, 0};
      vecs[1]  = '{1'b0, 14'h0100, 8'h00, 8'h3C, 0};
      vecs[2]  = '{1'b1, 14'h3E80, 8'h55, 8'h00, 0};
      vecs[3]  = '{1'b0, 14'h3E80, 8'h00, 8'h00, 0};
      vecs[4]  = '{1'b0, 14'h0100, 8'h00, 8'h3C, 5};
      vecs[5]  = '{1'b1, 14'h3E7F, 8'h77, 8'h00, 2};
      vecs[6]  = '{1'b0, 14'h3E7F, 8'h00, 8'h77, 1};
      vecs[7]  = '{1'b1, 14'h3FFF, 8'hAA, 8'h00, 0};
      vecs[8]  = '{1'b0, 14'h3FFF, 8'h00, 8'h00, 3};
      vecs[9]  = '{1'b1, 14'h0000, 8'h81, 8'h00, 0};
      vecs[10] = '{1'b0, 14'h0000, 8'h00, 8'h81, 0};

      // Preload RAM and the model with random bytes while reset is held.
      for (int i = 0; i < int'(MEMW); i++) begin
         d = 8'($urandom);
         ref_mem[i] = d;
         bd_write(AW'(i), d);
      end
      @(negedge pclk);
      chk("reset vid_valid", 32'(vid_valid), 0);
      chk("reset cpu_ack", 32'(cpu_ack), 0);
      chk("reset clr_busy", 32'(clr_busy), 0);
      chk("reset mem_we", 32'(mem_we), 0);
      chk("reset vid_data", 32'(vid_data), 0);
      chk("reset cpu_rdata", 32'(cpu_rdata), 0);
      chk("reset mem_addr", 32'(mem_addr), 0);
      chk("reset mem_wdata", 32'(mem_wdata), 0);
      step();
      reset = 1'b0;
      step();

      // Single video fetch of a known byte.
      bd_write(14'h0010, 8'hA5);
      ref_mem[16] = 8'hA5;
      vid_req  = 1'b1;
      vid_addr = 14'h0010;
      @(negedge pclk);
      chk("A5 fetch mem_addr", 32'(mem_addr), 'h10);
      step();
      vid_req = 1'b0;
      @(negedge pclk);
      chk("A5 +1 vid_valid", 32'(vid_valid), 0);
      step();
      @(negedge pclk);
      chk("A5 +2 vid_valid", 32'(vid_valid), 1);
      chk("A5 +2 vid_data", 32'(vid_data), 'hA5);
      step();

      // Table of host transactions.
      for (int i = 0; i < 11; i++) begin
         host_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rd, vecs[i].vid_hold);
      end

      // Random mix of video bursts and host accesses against the model image.
      for (int i = 0; i < 120; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                         : AW'($urandom_range(15984, 16015));
         if (kind == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
               vid_req  = 1'b1;
               vid_addr = a + AW'(k);
               step();
            end
            vid_req = 1'b0;
            step();
            step();
         end else if (kind == 1) begin
            host_op($sformatf("rnd%0d wr", i), 1'b1, a, 8'($urandom), 8'h00,
                    int'($urandom_range(0, 3)));
         end else begin
            host_op($sformatf("rnd%0d rd", i), 1'b0, a, 8'h00,
                    (32'(a) < VSIZE) ? ref_mem[a] : 8'h00, int'($urandom_range(0, 3)));
         end
      end

      // Full fill with video every 4th cycle, a pending host read and an ignored restart.
      vid_chk_en = 1'b0;
      bd_write(14'd16000, 8'h5A);
      ref_mem[16000] = 8'h5A;
      clr_value = 8'hE0;
      clr_start = 1'b1;
      @(negedge pclk);
      chk("fill busy in start cycle", 32'(clr_busy), 0);
      step();
      clr_start = 1'b0;
      clr_value = 8'h11;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 14'd5;
      busy_cyc = 0; vid_cyc = 0; seq = 0; bad_seq = 0; early = 0; cyc = 0; done = 0;
      while (!done && cyc < 40000) begin
         vid_req   = (cyc % 4 == 0);
         vid_addr  = AW'($urandom);
         clr_start = (cyc == 100);
         @(negedge pclk);
         if (!clr_busy) begin
            done = 1;
         end else begin
            busy_cyc++;
            if (vid_req) vid_cyc++;
            else begin
               if (!(mem_we === 1'b1 && int'(mem_addr) == seq && mem_wdata === 8'hE0))
                  bad_seq++;
               seq++;
            end
            if (cpu_ack) early++;
            step();
            cyc++;
         end
      end
      clr_start = 1'b0;
      chk("fill terminates", 32'(done), 1);
      chk("fill busy cycles", busy_cyc, VSIZE + vid_cyc);
      chk("fill write sequence", bad_seq, 0);
      chk("fill write count", seq, VSIZE);
      chk("no ack during fill", early, 0);
      g = -1; got = 0; bad = 0;
      for (int k = 0; k < 12 && !got; k++) begin
         if (k > 0) begin
            vid_req  = (cyc % 4 == 0);
            vid_addr = AW'($urandom);
            @(negedge pclk);
         end
         if (g < 0 && !vid_req) g = k;
         if (cpu_ack !== (g >= 0 && k == g + 2)) bad++;
         if (cpu_ack) begin
            got = 1;
            chk("read after fill rdata", 32'(cpu_rdata), 'hE0);
         end
         step();
         cyc++;
      end
      cpu_req = 1'b0;
      vid_req = 1'b0;
      last_rdata = 8'hE0;
      chk("read after fill acked", 32'(got), 1);
      chk("read after fill timing", bad, 0);
      bad = 0;
      for (int i = 0; i < int'(VSIZE); i++) if (ram[i] !== 8'hE0) bad++;
      chk("fill contents", bad, 0);
      chk("fill leaves 16000", 32'(ram[16000]), 'h5A);
      for (int i = 0; i < int'(VSIZE); i++) ref_mem[i] = 8'hE0;
      step();
      step();
      vid_chk_en = 1'b1;

      // Reset in the middle of a fill, just before address 500 is written.
      clr_value = 8'h99;
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      found = 0;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge pclk);
         if (mem_we && int'(mem_addr) == 500) found = 1;
         else step();
      end
      chk("fill reaches 500", 32'(found), 1);
      reset = 1'b1;
      #1;
      chk("mid-fill reset clr_busy", 32'(clr_busy), 0);
      chk("mid-fill reset mem_we", 32'(mem_we), 0);
      step();
      step();
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge pclk);
         if (clr_busy || mem_we || cpu_ack) bad++;
         step();
      end
      chk("quiet after mid-fill reset", bad, 0);
      bad = 0;
      for (int i = 0; i < 500; i++) if (ram[i] !== 8'h99) bad++;
      chk("fill below 500", bad, 0);
      bad = 0;
      for (int i = 500; i < int'(VSIZE); i++) if (ram[i] !== ref_mem[i]) bad++;
      chk("untouched from 500", bad, 0);
      for (int i = 0; i < 500; i++) ref_mem[i] = 8'h99;

      // Reset while a host read is waiting on RAM data: no ack afterwards.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 14'h0020;
      @(negedge pclk);
      chk("abort read grant", 32'(mem_addr), 'h20);
      step();
      @(negedge pclk);
      reset = 1'b1;
      #1;
      chk("abort cpu_ack", 32'(cpu_ack), 0);
      cpu_req = 1'b0;
      step();
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge pclk);
         if (cpu_ack) bad++;
         step();
      end
      chk("no ack after abort", bad, 0);
      chk("cpu_rdata after reset", 32'(cpu_rdata), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 14, meaning VRAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning VRAM data width (RGB332 pixel).
REQ-003 SHALL have parameter VRAM_SIZE, default 16000, meaning valid bytes (160x100).
REQ-004 SHALL have pclk  in  1  pixel clock; the single clock.
REQ-005 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have vid_req  in  1  video fetch strobe, one cycle per byte.
REQ-007 SHALL have vid_addr  in  AW  video fetch address.
REQ-008 SHALL have vid_data  out  DW  fetched video byte.
REQ-009 SHALL have vid_valid  out  1  vid_data qualifier.
REQ-010 SHALL have cpu_req  in  1  host request, held until cpu_ack.
REQ-011 SHALL have cpu_we  in  1  1 = write, 0 = read.
REQ-012 SHALL have cpu_addr  in  AW  host address.
REQ-013 SHALL have cpu_wdata  in  DW  host write data.
REQ-014 SHALL have cpu_rdata  out  DW  host read data.
REQ-015 SHALL have cpu_ack  out  1  one-cycle completion pulse.
REQ-016 SHALL have clr_start  in  1  pulse that starts a full-VRAM fill.
REQ-017 SHALL have clr_value  in  DW  fill byte, sampled on clr_start.
REQ-018 SHALL have clr_busy  out  1  fill in progress.
REQ-019 SHALL have mem_addr  out  AW, mem_we  out  1, mem_wdata  out  DW, and mem_rdata  in  DW: a single-port RAM with 1-cycle registered read.

Function
REQ-020 SHALL issue at most one memory access per cycle, with fixed priority video > fill > host.
REQ-021 SHALL present a video fetch on mem_addr in the same cycle as vid_req, and SHALL assert vid_valid with the data exactly 2 cycles after vid_req.
REQ-022 SHALL have a host FSM with states IDLE, WR_ACK, RD_WAIT and RD_ACK.
REQ-023 SHALL grant a host access in IDLE only when cpu_req=1, vid_req=0 and clr_busy=0.
REQ-024 SHALL complete a granted host write (IDLE->WR_ACK) with cpu_ack asserted 1 cycle after grant.
REQ-025 SHALL complete a granted host read (IDLE->RD_WAIT->RD_ACK) with cpu_ack and cpu_rdata asserted 2 cycles after grant; cpu_rdata SHALL hold until the next read.
REQ-026 SHALL return every FSM state to IDLE after cpu_ack, and SHALL NOT re-grant in the cycle cpu_ack is high.
REQ-027 SHALL handle a host address >= VRAM_SIZE without issuing a memory access: writes are dropped, reads return 0, and ack timing is unchanged.
REQ-028 SHALL, on clr_start, latch clr_value, set clr_busy and write addresses 0..VRAM_SIZE-1 in ascending order, one per cycle where video is idle; clr_busy SHALL clear the cycle after address VRAM_SIZE-1 is written.
REQ-029 SHALL ignore clr_start while clr_busy=1.
REQ-030 SHALL hold a host request pending during a fill, without ack, until the fill completes.
REQ-031 SHALL stall (not skip) the fill address whenever vid_req collides with it.
REQ-032 SHALL drive mem_we=0 in every cycle without a granted write.

Reset
REQ-033 SHALL, on reset, asynchronously drive vid_valid=0, cpu_ack=0, clr_busy=0 and mem_we=0; vid_data, cpu_rdata, mem_addr and mem_wdata SHALL reset to 0, and the FSM SHALL reset to IDLE.
REQ-034 SHALL abort any fill or host transaction in progress on reset, with no ack issued afterwards.

Structure
REQ-035 SHALL place AW, DW, VRAM_SIZE and the host FSM state enum in shared package vram_pkg.
REQ-036 SHALL implement the fill counter and address sequencing in one sub-module, vram_clear_seq.

Verification
REQ-037 SHALL cover: vid_req at addr 0x0010 holding 0xA5 -> vid_valid=1 with vid_data=0xA5 exactly 2 cycles later.
REQ-038 SHALL cover: host write 0x3C to 0x0100, then a read of 0x0100 -> write ack at +1, read ack at +2 with cpu_rdata=0x3C.
REQ-039 SHALL cover: host read held while vid_req is high every cycle for 5 cycles -> no ack until the first vid_req=0 cycle, then ack 2 cycles after grant.
REQ-040 SHALL cover: clr_start with clr_value=0xE0 and vid_req every 4th cycle -> all 16000 bytes read back 0xE0, and clr_busy stays high for 16000 + number-of-video-cycles cycles.
REQ-041 SHALL cover: host write to 0x3E80 (16000) then a read of it -> no mem_we, both acked, cpu_rdata=0x00.
REQ-042 SHALL cover: reset asserted mid-fill at address 500 -> clr_busy=0 and mem_we=0 immediately, with addresses >= 500 unmodified.
